branch_resolve_unit: RTL
========================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  pipeline freeze (IF or memory stall); all state holds.
REQ-005 if_pred_jump  input  1  predictor taken decision for the instruction in IF.
REQ-006 if_pred_pc  input  32  predictor target for the instruction in IF.
REQ-007 e_op  input  5  opcode[6:2] of the EX instruction; 5'b11000 = conditional branch.
REQ-008 e_funct3  input  3  funct3 of the EX instruction.
REQ-009 e_rs1, e_rs2  input  32 each  forwarded EX operands.
REQ-010 e_pc, e_imm  input  32 each  EX instruction PC and sign-extended B-immediate.
REQ-011 real_jump  output  1  actual branch outcome in EX, returned to the predictor.
REQ-012 redirect  output  1  mispredict recovery request to PC select.
REQ-013 redirect_pc  output  32  corrected fetch PC, valid when redirect=1.
REQ-014 flush_de  output  1  kill the IF/D and D/E pipeline registers; equals redirect.
REQ-015 branch_cnt, mispred_cnt  output  32 each  performance counters.

Function
REQ-016 The block SHALL carry the prediction through two stage registers: IF->D (pred_d, pred_pc_d) and D->E (pred_e, pred_pc_e).
- Both stage registers SHALL load on every clock with stall=0.
- Both SHALL hold on stall=1.
REQ-017 With redirect=1 and stall=0, pred_d and pred_e SHALL load 0 and pred_pc_d and pred_pc_e SHALL load 32'h0, so the killed slots become bubbles.
REQ-018 is_br = (e_op==5'b11000).
REQ-019 Branch outcome taken SHALL be decided by e_funct3:
- 000 taken when rs1==rs2; 001 taken when rs1!=rs2.
- 100 taken when signed rs1<rs2; 101 taken when signed rs1>=rs2.
- 110 taken when unsigned rs1<rs2; 111 taken when unsigned rs1>=rs2.
- 010 and 011 are never taken.
REQ-020 real_jump = is_br & taken & (state==NORMAL); combinational.
REQ-021 target = (e_pc + e_imm) & ~32'd1, modulo 2^32.
REQ-022 mispredict SHALL be any one of:
- taken & !pred_e;
- !taken & pred_e;
- taken & pred_e & (pred_pc_e != target).
REQ-023 redirect = is_br & mispredict & !stall & (state==NORMAL); combinational, zero-latency in EX.
REQ-024 redirect_pc SHALL equal target when taken, and e_pc+4 (wrapping) when not taken; it is don't-care when redirect=0.
REQ-025 The FSM SHALL have two states, NORMAL and RECOVER, plus a 2-bit recover counter rc.
REQ-026 FSM transitions:
- NORMAL -> RECOVER on redirect, with rc loaded to 2.
- In RECOVER with stall=0, rc decrements.
- RECOVER -> NORMAL when rc==1 and stall=0.
- With stall=1 the state and rc hold.
REQ-027 In RECOVER, EX branches SHALL be ignored: real_jump=0, redirect=0, and no counter update.
REQ-028 branch_cnt SHALL increment when is_br & !stall & NORMAL.
REQ-029 mispred_cnt SHALL increment when redirect=1.
REQ-030 Both counters SHALL saturate at 32'hFFFF_FFFF and never wrap.
REQ-031 When stall and a mispredicting branch coincide, nothing SHALL be counted or redirected until the first cycle with stall=0, which then acts exactly once.

Reset
REQ-032 While rst_n=0, independent of clk:
- state=NORMAL, rc=0;
- pred_d=pred_e=0, pred_pc_d=pred_pc_e=0;
- branch_cnt=mispred_cnt=0.
REQ-033 Consequently redirect=0 and flush_de=0 during reset, and real_jump=0 unless an EX branch is presented.
REQ-034 Reset asserted mid-RECOVER SHALL abort recovery; the first branch after release SHALL be evaluated in NORMAL.

Verification
REQ-035 Correct prediction: pred=1, pred_pc=0x100 at IF, then two stall-free cycles, then EX BEQ with rs1=rs2=5, e_pc=0xF0, e_imm=0x10 -> real_jump=1, redirect=0, branch_cnt=1, mispred_cnt=0.
REQ-036 Taken, not predicted: pred=0, then BNE with rs1=1, rs2=2, e_pc=0x200, e_imm=-8 -> redirect=1, redirect_pc=0x1F8, flush_de=1; the next two stall-free cycles ignore EX branches; mispred_cnt=1.
REQ-037 Predicted taken, falls through: pred=1, then BLT with rs1=5, rs2=-3 -> redirect=1, redirect_pc=e_pc+4. BLTU with the same operands is taken -> redirect=0 when the predicted target matches.
REQ-038 Target mismatch: pred=1, pred_pc=0x400, actual target 0x404 -> redirect=1, redirect_pc=0x404.
REQ-039 Stall plus saturation: mispredicting branch held 3 cycles with stall=1 -> redirect=0 throughout, then exactly one redirect and one count on release. Preload mispred_cnt to 32'hFFFF_FFFF -> it stays 32'hFFFF_FFFF.
REQ-040 Reset in RECOVER: rst_n pulsed low one cycle after a redirect -> all outputs and counters are 0, and a subsequent mispredicting branch redirects immediately.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// EX-stage conditional branch resolution: carries the IF prediction down to EX,
// compares it with the real outcome, requests redirect/flush and keeps perf counters.
module branch_resolve_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        if_pred_jump,
    input  logic [31:0] if_pred_pc,
    input  logic [4:0]  e_op,
    input  logic [2:0]  e_funct3,
    input  logic [31:0] e_rs1,
    input  logic [31:0] e_rs2,
    input  logic [31:0] e_pc,
    input  logic [31:0] e_imm,
    output logic        real_jump,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_de,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam logic ST_NORMAL  = 1'b0;
    localparam logic ST_RECOVER = 1'b1;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    logic        state_q, state_d;
    logic [1:0]  rc_q, rc_d;
    logic        pred_d_q, pred_d_d;
    logic [31:0] pred_pc_d_q, pred_pc_d_d;
    logic        pred_e_q, pred_e_d;
    logic [31:0] pred_pc_e_q, pred_pc_e_d;
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    logic        is_br;
    logic        taken;
    logic        normal;
    logic        mispredict;
    logic [31:0] target;

    always_comb begin
        case (e_funct3)
            3'b000:  taken = (e_rs1 == e_rs2);
            3'b001:  taken = (e_rs1 != e_rs2);
            3'b100:  taken = ($signed(e_rs1) <  $signed(e_rs2));
            3'b101:  taken = ($signed(e_rs1) >= $signed(e_rs2));
            3'b110:  taken = (e_rs1 <  e_rs2);
            3'b111:  taken = (e_rs1 >= e_rs2);
            default: taken = 1'b0;
        endcase
    end

    assign is_br      = (e_op == OP_BRANCH);
    assign normal     = (state_q == ST_NORMAL);
    assign target     = (e_pc + e_imm) & ~32'd1;
    assign mispredict = (taken & ~pred_e_q) | (~taken & pred_e_q)
                      | (taken & pred_e_q & (pred_pc_e_q != target));

    // redirect is held low while reset is asserted so no flush escapes during reset
    assign real_jump   = is_br & taken & normal;
    assign redirect    = is_br & mispredict & ~stall & normal & rst_n;
    assign redirect_pc = taken ? target : (e_pc + 32'd4);
    assign flush_de    = redirect;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    always_comb begin
        state_d       = state_q;
        rc_d          = rc_q;
        pred_d_d      = pred_d_q;
        pred_pc_d_d   = pred_pc_d_q;
        pred_e_d      = pred_e_q;
        pred_pc_e_d   = pred_pc_e_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (!stall) begin
            if (redirect) begin
                pred_d_d    = 1'b0;
                pred_pc_d_d = '0;
                pred_e_d    = 1'b0;
                pred_pc_e_d = '0;
            end else begin
                pred_d_d    = if_pred_jump;
                pred_pc_d_d = if_pred_pc;
                pred_e_d    = pred_d_q;
                pred_pc_e_d = pred_pc_d_q;
            end

            if (is_br && normal && (branch_cnt_q != '1))
                branch_cnt_d = branch_cnt_q + 32'd1;
            if (redirect && (mispred_cnt_q != '1))
                mispred_cnt_d = mispred_cnt_q + 32'd1;

            if (state_q == ST_NORMAL) begin
                if (redirect) begin
                    state_d = ST_RECOVER;
                    rc_d    = 2'd2;
                end
            end else begin
                rc_d = rc_q - 2'd1;
                if (rc_q == 2'd1)
                    state_d = ST_NORMAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_NORMAL;
            rc_q          <= '0;
            pred_d_q      <= 1'b0;
            pred_pc_d_q   <= '0;
            pred_e_q      <= 1'b0;
            pred_pc_e_q   <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            rc_q          <= rc_d;
            pred_d_q      <= pred_d_d;
            pred_pc_d_q   <= pred_pc_d_d;
            pred_e_q      <= pred_e_d;
            pred_pc_e_q   <= pred_pc_e_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule
